// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 4x4 matrix keypad scanner.
// Codes: digits 0-9 are their own value, '*' and '#' have dedicated codes, letters collapse to KEY_NONE.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_NONE = 4'hA;
    localparam logic [3:0] ROW_IDLE = 4'hF;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    function automatic logic row_valid(input logic [3:0] rows);
        logic ok;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] row_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational decode of a latched keypad position into the action it requests.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic       is_digit,
    output logic       is_start,
    output logic       is_cancel,
    output logic [3:0] value
);

    logic [3:0] code_s;

    // Classify the position's code; letters leave every flag low.
    always_comb begin
        code_s    = key_map(row_idx, col_idx);
        is_digit  = 1'b0;
        is_start  = 1'b0;
        is_cancel = 1'b0;
        value     = 4'h0;
        if (code_s <= 4'h9) begin
            is_digit = 1'b1;
            value    = code_s;
        end else if (code_s == KEY_HASH) begin
            is_start = 1'b1;
        end else if (code_s == KEY_STAR) begin
            is_cancel = 1'b1;
        end else begin
            value = 4'h0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner with press/release debounce for a 4x4 active-low keypad.
// Emits single-cycle pressed/start/cancel pulses; key_value holds the last accepted digit.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       pressed,
    output logic [3:0] key_value,
    output logic       start,
    output logic       cancel
);

    localparam int               CNT_TOP     = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int               CNT_W       = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [1:0]       cidx_q, cidx_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       krow_q, krow_d;
    logic [1:0]       kcol_q, kcol_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic             pressed_q, pressed_d;
    logic             start_q, start_d;
    logic             cancel_q, cancel_d;
    logic [3:0]       key_value_q, key_value_d;
    logic             km_digit_s, km_start_s, km_cancel_s;
    logic [3:0]       km_value_s;

    keypad_keymap u_keymap (
        .row_idx   (krow_q),
        .col_idx   (kcol_q),
        .is_digit  (km_digit_s),
        .is_start  (km_start_s),
        .is_cancel (km_cancel_s),
        .value     (km_value_s)
    );

    assign cnt_inc_s = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state: scan dwell, debounce confirm, hold-until-release, and pulse generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cidx_d      = cidx_q;
        krow_d      = krow_q;
        kcol_d      = kcol_q;
        key_value_d = key_value_q;
        pressed_d   = 1'b0;
        start_d     = 1'b0;
        cancel_d    = 1'b0;
        sync1_d     = row_in;
        sync2_d     = sync1_q;
        case (state_q)
            ST_SCAN: begin
                // Sample only on the last dwell cycle so the synchronizer reflects this column.
                if (cnt_q >= DWELL_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (row_valid(sync2_q)) begin
                        krow_d  = row_index(sync2_q);
                        kcol_d  = cidx_q;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        cidx_d = cidx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_DEBOUNCE: begin
                if (sync2_q == row_pattern(krow_q)) begin
                    if (cnt_q >= STABLE_LAST) begin
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_HOLD;
                        pressed_d = km_digit_s;
                        start_d   = km_start_s;
                        cancel_d  = km_cancel_s;
                        if (km_digit_s) begin
                            key_value_d = km_value_s;
                        end else begin
                            key_value_d = key_value_q;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    state_d = ST_SCAN;
                    cnt_d   = CNT_ZERO;
                    cidx_d  = cidx_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (sync2_q == ROW_IDLE) begin
                    if (cnt_q >= STABLE_LAST) begin
                        state_d = ST_SCAN;
                        cnt_d   = CNT_ZERO;
                        cidx_d  = cidx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = CNT_ZERO;
                cidx_d  = 2'd0;
            end
        endcase
        col_d = ~(4'b0001 << cidx_d);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_SCAN;
            cnt_q       <= CNT_ZERO;
            cidx_q      <= 2'd0;
            col_q       <= 4'b1110;
            krow_q      <= 2'd0;
            kcol_q      <= 2'd0;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            pressed_q   <= 1'b0;
            start_q     <= 1'b0;
            cancel_q    <= 1'b0;
            key_value_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cidx_q      <= cidx_d;
            col_q       <= col_d;
            krow_q      <= krow_d;
            kcol_q      <= kcol_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pressed_q   <= pressed_d;
            start_q     <= start_d;
            cancel_q    <= cancel_d;
            key_value_q <= key_value_d;
        end
    end

    assign col_out   = col_q;
    assign pressed   = pressed_q;
    assign start     = start_q;
    assign cancel    = cancel_q;
    assign key_value = key_value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model, a cycle model of the scan/debounce rules
// checked every cycle, and directed key sequences with hand-computed timing and values.
module tb_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 20;
    localparam int SCANNING   = 0;
    localparam int CONFIRMING = 1;
    localparam int HELD       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        pressed;
    logic [3:0]  key_value;
    logic        start;
    logic        cancel;
    logic [15:0] keys_down;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .pressed   (pressed),
        .key_value (key_value),
        .start     (start),
        .cancel    (cancel)
    );

    always #5 clk = ~clk;

    // A row reads low when any held key on it sits in the currently driven column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
    end

    logic [3:0] smp_row;
    logic       smp_rst;
    always @(posedge clk) begin
        smp_row <= row_in;
        smp_rst <= rst_n;
    end

    int n_pressed = 0, n_start = 0, n_cancel = 0;
    always @(posedge clk) begin
        if (pressed === 1'b1) n_pressed <= n_pressed + 1;
        if (start === 1'b1)   n_start   <= n_start + 1;
        if (cancel === 1'b1)  n_cancel  <= n_cancel + 1;
    end

    // Reference model state: what the scanner is doing, in terms of columns, ticks and a key position.
    string      key_chars = "123A456B789C*0#D";
    int         m_mode = SCANNING, m_col = 0, m_ticks = 0, m_krow = 0;
    logic [3:0] h1 = 4'hF, h2 = 4'hF;
    logic [3:0] e_col = 4'b1110, e_val = 4'h0;
    logic       e_pressed = 1'b0, e_start = 1'b0, e_cancel = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] row, input logic rst);
        logic [3:0] rs, want, one;
        int         lows, lowrow;
        byte        ch;
        one = 4'b0001;
        rs  = h2;
        h2  = h1;
        h1  = row;
        e_pressed = 1'b0;
        e_start   = 1'b0;
        e_cancel  = 1'b0;
        if (rst !== 1'b0) begin
            h1 = 4'hF; h2 = 4'hF;
            m_mode = SCANNING; m_col = 0; m_ticks = 0; e_val = 4'h0;
        end else if (m_mode == SCANNING) begin
            m_ticks++;
            if (m_ticks == SCAN_DIV) begin
                m_ticks = 0; lows = 0; lowrow = 0;
                for (int r = 0; r < 4; r++)
                    if (rs[r] === 1'b0) begin lows++; lowrow = r; end
                if (lows == 1) begin
                    m_krow = lowrow;
                    m_mode = CONFIRMING;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
        end else if (m_mode == CONFIRMING) begin
            want = ~(one << m_krow);
            if (rs === want) begin
                m_ticks++;
                if (m_ticks == DEBOUNCE) begin
                    m_ticks = 0;
                    m_mode  = HELD;
                    ch = key_chars[m_krow*4 + m_col];
                    if (ch >= 8'h30 && ch <= 8'h39) begin
                        e_pressed = 1'b1;
                        e_val     = 4'(ch - 8'h30);
                    end else if (ch == 8'h23) begin
                        e_start = 1'b1;
                    end else if (ch == 8'h2A) begin
                        e_cancel = 1'b1;
                    end
                end
            end else begin
                m_ticks = 0; m_mode = SCANNING; m_col = (m_col + 1) % 4;
            end
        end else begin
            if (rs === 4'hF) begin
                m_ticks++;
                if (m_ticks == DEBOUNCE) begin
                    m_ticks = 0; m_mode = SCANNING; m_col = (m_col + 1) % 4;
                end
            end else begin
                m_ticks = 0;
            end
        end
        e_col = ~(one << m_col);
    endtask

    task automatic wait_for(input int which, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && pressed === 1'b1) || (which == 1 && start === 1'b1) ||
                (which == 2 && cancel === 1'b1)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (col_out === target) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic release_all();
        keys_down = 16'h0000;
        repeat (45) @(negedge clk);
    endtask

    int cyc, bp, bs, bc;
    bit seen3;

    initial begin
        rst_n     = 1'b1;
        keys_down = 16'h0000;
        fork
            forever begin
                @(negedge clk);
                model_step(smp_row, smp_rst);
                if (chk_en) begin
                    check("col_out", col_out, e_col);
                    check("pressed", pressed, e_pressed);
                    check("start", start, e_start);
                    check("cancel", cancel, e_cancel);
                    check("key_value", key_value, e_val);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_col", col_out, 4'b1110);
        check("rst_pressed", pressed, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_cancel", cancel, 1'b0);
        check("rst_value", key_value, 4'h0);

        // Clean '5' held from reset release: col1 seen at cycle 7, fires 20 cycles later.
        keys_down[5] = 1'b1;
        rst_n = 1'b0;
        wait_for(0, 60, cyc);
        check("latency_5", cyc, 28);
        check("value_5", key_value, 4'd5);
        repeat (40) @(negedge clk);
        keys_down = 16'h0000;
        wait_col(4'b1011, 40, cyc);
        check("resume_col2", cyc, 22);
        check("count_5", n_pressed, 1);

        // Bouncy '0'.
        bp = n_pressed;
        for (int i = 0; i < 5; i++) begin
            keys_down[13] = ~keys_down[13];
            repeat (3) @(negedge clk);
        end
        keys_down[13] = 1'b1;
        wait_for(0, 200, cyc);
        check("bounce_0_seen", (cyc > 0), 1'b1);
        check("value_0", key_value, 4'd0);
        repeat (10) @(negedge clk);
        check("count_0", n_pressed - bp, 1);
        release_all();

        // '1', then '#', then '*'.
        bp = n_pressed; bs = n_start; bc = n_cancel;
        keys_down[0] = 1'b1;
        wait_for(0, 100, cyc);
        check("key1_seen", (cyc > 0), 1'b1);
        check("value_1", key_value, 4'd1);
        release_all();
        keys_down[14] = 1'b1;
        wait_for(1, 100, cyc);
        check("hash_seen", (cyc > 0), 1'b1);
        check("hash_no_pressed", pressed, 1'b0);
        check("hash_value_kept", key_value, 4'd1);
        release_all();
        keys_down[12] = 1'b1;
        wait_for(2, 100, cyc);
        check("star_seen", (cyc > 0), 1'b1);
        check("star_no_pressed", pressed, 1'b0);
        check("star_no_start", start, 1'b0);
        release_all();
        check("seq_pressed", n_pressed - bp, 1);
        check("seq_start", n_start - bs, 1);
        check("seq_cancel", n_cancel - bc, 1);

        // Keys 2 and 8 together in col1: invalid code, scan keeps moving.
        bp = n_pressed; bs = n_start; bc = n_cancel;
        keys_down[1] = 1'b1;
        keys_down[9] = 1'b1;
        seen3 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_out === 4'b0111) seen3 = 1'b1;
        end
        check("multi_scan_continues", seen3, 1'b1);
        release_all();

        // 'B': held silently, column frozen until release.
        keys_down[7] = 1'b1;
        repeat (80) @(negedge clk);
        check("b_frozen", col_out, 4'b0111);
        keys_down = 16'h0000;
        wait_col(4'b1110, 40, cyc);
        check("b_resume", cyc, 22);
        check("silent_pulses", (n_pressed - bp) + (n_start - bs) + (n_cancel - bc), 0);
        repeat (10) @(negedge clk);

        // '7' held 500 cycles, '9' added midway, then '9' alone.
        bp = n_pressed;
        keys_down[8] = 1'b1;
        repeat (250) @(negedge clk);
        keys_down[10] = 1'b1;
        repeat (250) @(negedge clk);
        check("hold7_count", n_pressed - bp, 1);
        check("value_7", key_value, 4'd7);
        release_all();
        check("nine_while_held", n_pressed - bp, 1);
        keys_down[10] = 1'b1;
        wait_for(0, 100, cyc);
        check("key9_seen", (cyc > 0), 1'b1);
        check("value_9", key_value, 4'd9);
        repeat (10) @(negedge clk);
        release_all();

        // Reset while a key is in HOLD.
        keys_down[5] = 1'b1;
        wait_for(0, 100, cyc);
        check("key5b_seen", (cyc > 0), 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hold_rst_col", col_out, 4'b1110);
        check("hold_rst_pressed", pressed, 1'b0);
        check("hold_rst_value", key_value, 4'h0);
        rst_n = 1'b0;
        keys_down = 16'h0000;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad and debounces presses. It is the producer side of the Amount_Manager key interface: it emits a one-cycle pressed pulse with key_value for digits 0-9, a start pulse for '#', and a cancel pulse for '*'. It runs on the 1000 Hz divided clock shared with the amount and timing logic.

Parameters:
SCAN_DIV, 4, clk cycles each column stays driven while scanning (>=3)
DEBOUNCE, 20, consecutive stable cycles required on press and on release (>=2)

Ports:
clk  input  1  1000 Hz system clock
rst_n  input  1  synchronous reset, active-high despite the name; sampled on posedge clk
row_in  input  4  keypad rows, active-low, asynchronous to clk
col_out  output  4  column drive, one-hot active-low
pressed  output  1  one-cycle pulse, a digit key has been accepted
key_value  output  4  digit 0-9; valid in the pressed cycle and held until the next accepted digit
start  output  1  one-cycle pulse, '#' accepted
cancel  output  1  one-cycle pulse, '*' accepted

Behaviour:
- Reset (rst_n=1 at posedge): col_out=4'b1110, pressed=start=cancel=0, key_value=0, state=SCAN, counters=0, sync flops=4'hF. Reset overrides everything, including mid-debounce and held keys.
- row_in passes through a 2-flop synchronizer; row_s is the second flop. All decisions below use row_s.
- Key map (row r, col c): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D. A-D are accepted but produce no output pulse.
- Valid code: row_s has exactly one bit low. Zero or multiple bits low means no key.
- State SCAN:
  - Column index cidx advances (0->1->2->3->0) every SCAN_DIV cycles. col_out = ~(1<<cidx).
  - On the last dwell cycle, if row_s is a valid code: latch {row, cidx} into kcode, freeze the column, clear the counter, go to DEBOUNCE.
- State DEBOUNCE:
  - Each cycle that row_s equals the latched row increments the counter.
  - Any mismatch (bounce, release, extra key) returns to SCAN. The counter clears and the scan resumes at cidx+1.
  - When the counter reaches DEBOUNCE-1 with a match, the next cycle fires the output for kcode and enters HOLD. Press latency is exactly DEBOUNCE cycles after entering DEBOUNCE.
- Output fire:
  - Digit: pressed=1 and key_value updated in the same cycle.
  - '#': start=1. '*': cancel=1.
  - At most one pulse per cycle; each pulse lasts exactly one cycle.
- State HOLD:
  - Column stays frozen; no repeat pulses while held.
  - row_s==4'hF starts the release count. Any non-F value restarts the count.
  - DEBOUNCE consecutive 4'hF cycles return to SCAN at cidx+1.
  - A second key pressed while the first is held gives no output.
- Counter width is $clog2(max(SCAN_DIV,DEBOUNCE)+1); it saturates and never wraps.
- Timing: start must follow pressed by at least DEBOUNCE cycles, which is inherent in the protocol.

Decomposition:
- Shared package keypad_pkg: state enum {SCAN, DEBOUNCE, HOLD}; constants KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_NONE; the 16-entry key-map function from position to code.
- One natural sub-module, keypad_keymap: combinational map from {row,col} to {is_digit, is_start, is_cancel, value}. The FSM, scan and debounce logic stay in keypad_scanner.

Test Plan:
- Reset -> col_out=1110, all pulses 0, key_value=0. Assert rst_n during HOLD -> next cycle col_out=1110, state SCAN, no pulse.
- Clean '5' (row1 low while col1 driven, held 40 cycles), SCAN_DIV=4, DEBOUNCE=20 -> exactly one pressed pulse, key_value=5, 20 cycles after detection. Release 20 cycles -> scan resumes with col2 (1011).
- Bouncy '0' (row3 toggling every 3 cycles for 15 cycles, then stable) -> no pulse during bounce, then one pressed with key_value=0.
- '1' then '#' as separate presses -> pressed with key_value=1, then later start=1 with pressed=0 in that cycle. '*' -> cancel=1 only.
- Two rows low in the same column (keys 2 and 8) -> no pulse, scan continues. Key 'B' -> no pulse, but HOLD is still entered and the scan resumes only after release.
- Hold '7' for 500 cycles -> single pressed pulse. Press '9' while '7' is held -> no output until both are released and '9' is pressed again.
